cpu16_mem_sys: RTL and testbench



---
 rtl/cpu16_mem_sys_if.sv | 26 ++
 rtl/cpu16_mem_sys.sv | 125 ++++++++++++
 tb/tb_cpu16_mem_sys.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu16_mem_sys_if.sv
// Memory bus between the 16-bit CPU and its memory system, plus the boot-loader byte stream.
// The master side is the CPU / loader source; the slave side is cpu16_mem_sys.
interface cpu16_mem_sys_if #(
  parameter int bw = 16,
  parameter int aw = 9
);
  logic [aw-1:0] addr;
  logic          mw;
  logic [bw-1:0] wdata;
  logic [bw-1:0] rdata;

  logic          ld_valid;
  logic [7:0]    ld_byte;
  logic          ld_last;
  logic          ld_ready;

  modport master (
    output addr, mw, wdata, ld_valid, ld_byte, ld_last,
    input  rdata, ld_ready
  );

  modport slave (
    input  addr, mw, wdata, ld_valid, ld_byte, ld_last,
    output rdata, ld_ready
  );
endinterface

// File: rtl/cpu16_mem_sys.sv
// 512 x 16 RAM with one memory-mapped I/O word and a big-endian byte-stream boot loader.
// The CPU is held in reset while the image loads, then released to run against the RAM.
module cpu16_mem_sys #(
  parameter int            bw      = 16,
  parameter int            aw      = 9,
  parameter logic [aw-1:0] IO_ADDR = 9'h1FF
) (
  input  logic                clk,
  input  logic                rst,
  cpu16_mem_sys_if.slave      bus,
  output logic                cpu_rst_o,
  output logic                ld_ovf_o,
  output logic [bw-1:0]       io_out_o,
  input  logic [bw-1:0]       io_in_i
);

  localparam int unsigned DEPTH = 2 ** aw;

  typedef enum logic { LOAD, RUN } state_e;
  typedef enum logic { HIGH, LOW } phase_e;

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [aw:0]   cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic          ovf_q, ovf_d;
  logic [bw-1:0] io_out_q, io_out_d;

  logic [bw-1:0] mem [DEPTH];
  logic          mem_we;
  logic [aw-1:0] mem_waddr;
  logic [bw-1:0] mem_wdata;
  logic          xfer;
  logic          io_sel;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == LOAD && xfer && bus.ld_last) state_d = RUN;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.ld_ready = (state_q == LOAD);
    cpu_rst_o    = (state_q == LOAD);
  end

  assign xfer = bus.ld_valid && bus.ld_ready;

  // Loader assembly and CPU writes share the single RAM write port; state picks the owner.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    ovf_d     = ovf_q;
    io_out_d  = io_out_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q[aw-1:0];
    mem_wdata = {hi_q, bus.ld_byte};

    if (state_q == LOAD) begin
      if (xfer) begin
        if (phase_q == HIGH && !bus.ld_last) begin
          hi_d    = bus.ld_byte;
          phase_d = LOW;
        end else begin
          // A final byte in the HIGH phase becomes a word padded with a zero low byte.
          phase_d   = HIGH;
          mem_wdata = (phase_q == HIGH) ? {bus.ld_byte, 8'h00} : {hi_q, bus.ld_byte};
          if (cnt_q[aw]) begin
            ovf_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
    end else if (bus.mw) begin
      if (bus.addr == IO_ADDR) begin
        io_out_d = bus.wdata;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = bus.addr;
        mem_wdata = bus.wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= HIGH;
      cnt_q    <= '0;
      hi_q     <= '0;
      ovf_q    <= 1'b0;
      io_out_q <= '0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      ovf_q    <= ovf_d;
      io_out_q <= io_out_d;
    end
  end

  // NOTE: the RAM array has no reset; its contents must survive rst, and clearing it would defeat RAM inference.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Asynchronous read so the CPU sees data in the same cycle it presents the address.
  assign io_sel    = (state_q == RUN) && (bus.addr == IO_ADDR);
  assign bus.rdata = io_sel ? io_in_i : mem[bus.addr];

  assign ld_ovf_o  = ovf_q;
  assign io_out_o  = io_out_q;

endmodule

// File: tb/tb_cpu16_mem_sys.sv
// Directed self-checking bench for cpu16_mem_sys: loader, overflow, reset, CPU and I/O accesses.
// Expected read data is queued when a read is issued and compared when the data is sampled.
module tb_cpu16_mem_sys;

  logic        clk;
  logic        rst;
  logic        cpu_rst;
  logic        ld_ovf;
  logic [15:0] io_out;
  logic [15:0] io_in;

  cpu16_mem_sys_if #(.bw(16), .aw(9)) bus ();

  cpu16_mem_sys #(.bw(16), .aw(9), .IO_ADDR(9'h1FF)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .cpu_rst_o (cpu_rst),
    .ld_ovf_o  (ld_ovf),
    .io_out_o  (io_out),
    .io_in_i   (io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] img_word(input int i);
    logic [31:0] t;
    t = i * 37 + 4096;
    return t[15:0] ^ 16'hA5A5;
  endfunction

  // All tasks are entered and left just after a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    #1;
    if (bus.ld_ready !== 1'b1) check("ld_ready_during_load", {15'd0, bus.ld_ready}, 16'd1);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [8:0] a, input logic [15:0] exp);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.exp = exp;
    bus.mw   = 1'b0;
    bus.addr = a;
    sb_q.push_back(e);
    @(negedge clk);
    got = sb_q.pop_front();
    check(got.tag, bus.rdata, got.exp);
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [15:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.mw    = 1'b1;
    @(negedge clk);
    bus.mw    = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    io_in        = 16'h0000;
    bus.addr     = '0;
    bus.mw       = 1'b0;
    bus.wdata    = '0;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = '0;
    bus.ld_last  = 1'b0;
    repeat (2) @(negedge clk);

    // ---- 1: reset values, then a two-word image ----
    do_reset();
    check("rst_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    check("rst_ld_ready", {15'd0, bus.ld_ready}, 16'd1);
    check("rst_ld_ovf", {15'd0, ld_ovf}, 16'd0);
    check("rst_io_out", io_out, 16'h0000);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    check("t1_cpu_rst_before_last", {15'd0, cpu_rst}, 16'd1);
    send_byte(8'hCD, 1'b1);
    check("t1_cpu_rst_after_last", {15'd0, cpu_rst}, 16'd0);
    check("t1_ld_ready_run", {15'd0, bus.ld_ready}, 16'd0);
    check("t1_ld_ovf", {15'd0, ld_ovf}, 16'd0);
    read_chk("t1_ram0", 9'h000, 16'h1234);
    read_chk("t1_ram1", 9'h001, 16'hABCD);

    // ---- 2: odd byte count pads the last word ----
    do_reset();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check("t2_cpu_rst_run", {15'd0, cpu_rst}, 16'd0);
    read_chk("t2_ram0", 9'h000, 16'h1122);
    read_chk("t2_ram1", 9'h001, 16'h3300);

    // ---- 3: CPU RAM write, read-during-write, I/O port ----
    cpu_write(9'h005, 16'h1111);
    read_chk("t3_ram5_first", 9'h005, 16'h1111);
    bus.addr  = 9'h005;
    bus.wdata = 16'hBEEF;
    bus.mw    = 1'b1;
    #1;
    check("t3_rdw_old", bus.rdata, 16'h1111);
    @(negedge clk);
    bus.mw = 1'b0;
    check("t3_rdw_new", bus.rdata, 16'hBEEF);
    io_in = 16'h5A5A;
    cpu_write(9'h1FF, 16'h00A5);
    check("t3_io_out", io_out, 16'h00A5);
    read_chk("t3_io_in", 9'h1FF, 16'h5A5A);

    // ---- 4: 513-word image overflows; RAM survives reset ----
    do_reset();
    check("t4_io_out_cleared", io_out, 16'h0000);
    for (int i = 0; i < 513; i++) begin
      logic [15:0] w;
      w = img_word(i);
      if (i == 512) check("t4_ovf_before_513", {15'd0, ld_ovf}, 16'd0);
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], i == 512);
    end
    check("t4_ovf_set", {15'd0, ld_ovf}, 16'd1);
    check("t4_run", {15'd0, cpu_rst}, 16'd0);
    read_chk("t4_ram0", 9'h000, img_word(0));
    read_chk("t4_ram1", 9'h001, img_word(1));
    read_chk("t4_ram255", 9'h0FF, img_word(255));
    read_chk("t4_ram510", 9'h1FE, img_word(510));
    io_in = 16'hC001;
    cpu_write(9'h1FF, 16'h1234);
    check("t4_io_out", io_out, 16'h1234);
    do_reset();
    check("t4_ovf_cleared", {15'd0, ld_ovf}, 16'd0);
    check("t4_io_out_rst", io_out, 16'h0000);
    read_chk("t4_ram511_load", 9'h1FF, img_word(511));
    read_chk("t4_ram256_load", 9'h100, img_word(256));
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b1);
    read_chk("t4_reload_ram0", 9'h000, 16'hDEAD);
    read_chk("t4_retain_ram1", 9'h001, img_word(1));
    read_chk("t4_retain_ram510", 9'h1FE, img_word(510));

    // ---- 5: reset mid-load drops the staged byte; CPU writes ignored in LOAD ----
    do_reset();
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h99, 1'b0);
    do_reset();
    check("t5_cpu_rst", {15'd0, cpu_rst}, 16'd1);
    cpu_write(9'h000, 16'hFFFF);
    read_chk("t5_load_ram0_nowrite", 9'h000, 16'h7788);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b1);
    read_chk("t5_ram0", 9'h000, 16'hAABB);
    read_chk("t5_ram1_untouched", 9'h001, img_word(1));

    // ---- 6: idle gap inside a word; loader ignored in RUN ----
    do_reset();
    send_byte(8'h5C, 1'b0);
    repeat (20) @(negedge clk);
    check("t6_ready_idle", {15'd0, bus.ld_ready}, 16'd1);
    send_byte(8'h3D, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_byte  = 8'hF0 + 8'(k);
      bus.ld_last  = k[0];
      #1;
      check("t6_ready_run", {15'd0, bus.ld_ready}, 16'd0);
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    check("t6_still_run", {15'd0, cpu_rst}, 16'd0);
    read_chk("t6_ram0", 9'h000, 16'h5C3D);
    read_chk("t6_ram1", 9'h001, img_word(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
